// File: rtl/phone_input_port_if.sv
// CPU-side read bus of phone_input_port: read strobe/select in, registered data and flags out.
interface phone_input_port_if #(
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic              rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              pending;
  logic              irq;

  modport master (
    output rd_req, rd_sel,
    input  rd_data, rd_valid, pending, irq
  );

  modport slave (
    input  rd_req, rd_sel,
    output rd_data, rd_valid, pending, irq
  );
endinterface

// File: rtl/phone_input_port.sv
// Phone input port: per-line 2-flop sync + debounce, stable snapshot, change/overflow flags, CPU read port.
// Optional macro PHONE_INPUT_IRQ_EN turns irq into a registered copy of pending; otherwise irq is tied 0.

module phone_input_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_stable,
  output logic o_upd
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic r_s1, r_s2, r_stable;

  // Plain two-flop chain; nothing may sit between r_s1 and r_s2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stable <= 1'b0;
        else      r_stable <= r_s2;
      end
      assign o_upd = (r_s2 != r_stable);
    end else begin : g_debounce
      localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] r_cnt;

      // Counter tracks the current run of mismatches; any match restarts it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == LIM) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign o_upd = (r_s2 != r_stable) && (r_cnt == LIM);
    end
  endgenerate

  assign o_stable = r_stable;
endmodule

module phone_input_port #(
  parameter int NUM_IN          = 8,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit BIT_REVERSE     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] in_pins,
  phone_input_port_if.slave bus
);
  generate
    if (NUM_IN > DATA_W || NUM_IN < 1 || NUM_IN > 16) begin : g_bad_cfg
      $fatal(1, "phone_input_port: NUM_IN must be 1..16 and not exceed DATA_W");
    end
  endgenerate

  logic [NUM_IN-1:0] w_stable;
  logic [NUM_IN-1:0] w_upd;
  logic [NUM_IN-1:0] w_snap;
  logic [DATA_W-1:0] w_snap_ext;
  logic [DATA_W-1:0] w_stat;
  logic              w_any_upd;
  logic              w_data_rd;
  logic              w_coll;

  logic              r_chg;
  logic              r_pending;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      phone_input_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i_pin    (in_pins[gi]),
        .o_stable (w_stable[gi]),
        .o_upd    (w_upd[gi])
      );
      if (BIT_REVERSE) begin : g_rev
        assign w_snap[NUM_IN-1-gi] = w_stable[gi];
      end else begin : g_fwd
        assign w_snap[gi] = w_stable[gi];
      end
    end
  endgenerate

  always_comb begin
    w_snap_ext             = '0;
    w_snap_ext[NUM_IN-1:0] = w_snap;
    w_stat                 = '0;
    w_stat[1:0]            = {r_overflow, r_pending};
  end

  assign w_any_upd = |w_upd;
  assign w_data_rd = bus.rd_req & ~bus.rd_sel;
  // A data read coinciding with an update returns the old snapshot, so the
  // update is folded straight into pending instead of raising r_chg next cycle.
  assign w_coll    = w_data_rd & w_any_upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chg      <= 1'b0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_chg      <= w_any_upd & ~w_coll;
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req)
        r_rd_data <= bus.rd_sel ? w_stat : w_snap_ext;
      if (w_data_rd) begin
        r_overflow <= 1'b0;
        r_pending  <= r_chg | w_coll;
      end else if (r_chg) begin
        r_overflow <= r_overflow | r_pending;
        r_pending  <= 1'b1;
      end
    end
  end

`ifdef PHONE_INPUT_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= r_pending;
  end
  assign bus.irq = r_irq;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.pending  = r_pending;
endmodule

// File: tb/tb_phone_input_port.sv
// Directed + random bench for phone_input_port (NUM_IN=8, DATA_W=16, DEBOUNCE_CYCLES=4, BIT_REVERSE=1).
module tb_phone_input_port;
  localparam int DC = 4;
`ifdef PHONE_INPUT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pins = 8'hFF;
  int         errs = 0;
  int         checks = 0;

  phone_input_port_if #(.DATA_W(16)) bus ();

  phone_input_port #(
    .NUM_IN(8), .DATA_W(16), .DEBOUNCE_CYCLES(DC), .BIT_REVERSE(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_pins (pins),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pin history feeds a per-line "mismatch run length";
  // a line adopts its synced value once the run reaches DC cycles.
  logic [7:0]  m_s1, m_s2, m_st;
  int          m_run [8];
  logic        m_pend, m_ovf, m_chg, m_irq, m_valid;
  logic [15:0] m_data;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_pend = 0; m_ovf = 0; m_chg = 0; m_irq = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic model_edge();
    logic [7:0] nst;
    logic any, rd, dr, coll;
    nst = m_st;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] >= DC) begin
          nst[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    any  = (nst != m_st);
    rd   = bus.rd_req;
    dr   = rd & ~bus.rd_sel;
    coll = dr & any;
    m_irq   = IRQ_ON & m_pend;
    m_valid = rd;
    if (rd) m_data = bus.rd_sel ? {14'b0, m_ovf, m_pend} : {8'b0, rev8(m_st)};
    if (dr) begin
      m_ovf  = 0;
      m_pend = m_chg | coll;
    end else if (m_chg) begin
      m_ovf  = m_ovf | m_pend;
      m_pend = 1;
    end
    m_chg = any & ~coll;
    m_st  = nst;
    m_s2  = m_s1;
    m_s1  = pins;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"},   16'(bus.rd_valid), 16'(m_valid));
    chk({tag, ".data"},    bus.rd_data,       m_data);
    chk({tag, ".pending"}, 16'(bus.pending),  16'(m_pend));
    chk({tag, ".irq"},     16'(bus.irq),      16'(m_irq));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all("model");
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic rd(input logic sel);
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
    cyc();
    bus.rd_req = 1'b0;
  endtask

  initial begin
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    model_reset();

    // Reset with all pins high: everything stays zero.
    #3;
    chk("rst.data",    bus.rd_data,       16'h0000);
    chk("rst.valid",   16'(bus.rd_valid), 16'h0);
    chk("rst.pending", 16'(bus.pending),  16'h0);
    chk("rst.irq",     16'(bus.irq),      16'h0);
    cycn(3);
    chk("rst.hold_pending", 16'(bus.pending), 16'h0);

    // Release: stable takes FF at edge 2+DC, pending follows one edge later.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycn(2 + DC);
    chk("rel.pend_lo", 16'(bus.pending), 16'h0);
    cyc();
    chk("rel.pend_hi", 16'(bus.pending), 16'h1);
    chk("rel.irq_lag", 16'(bus.irq), 16'h0);
    cyc();
    chk("rel.irq_on", 16'(bus.irq), 16'(IRQ_ON));
    rd(1'b0);
    chk("rel.snap", bus.rd_data, 16'h00FF);
    chk("rel.clr",  16'(bus.pending), 16'h0);
    cyc();
    chk("rel.irq_off", 16'(bus.irq), 16'h0);

    // Settle to zero and clear.
    pins = 8'h00;
    cycn(10);
    rd(1'b0);

    // Glitch shorter than the debounce window is rejected.
    pins = 8'h01;
    cycn(3);
    pins = 8'h00;
    cycn(10);
    chk("glitch.pend", 16'(bus.pending), 16'h0);
    rd(1'b0);
    chk("glitch.snap", bus.rd_data, 16'h0000);

    // Held long enough: pending on edge 7 after the pin change.
    pins = 8'h01;
    cycn(6);
    chk("deb.pend6", 16'(bus.pending), 16'h0);
    cyc();
    chk("deb.pend7", 16'(bus.pending), 16'h1);
    cyc();
    chk("deb.irq", 16'(bus.irq), 16'(IRQ_ON));
    rd(1'b0);
    chk("rd.data", bus.rd_data, 16'h0080);
    chk("rd.valid", 16'(bus.rd_valid), 16'h1);
    chk("rd.pend", 16'(bus.pending), 16'h0);
    cyc();
    chk("rd.valid_drop", 16'(bus.rd_valid), 16'h0);
    chk("rd.data_hold", bus.rd_data, 16'h0080);

    // Two changes without a read set overflow.
    pins = 8'h03;
    cycn(8);
    pins = 8'h02;
    cycn(8);
    rd(1'b1);
    chk("stat.both", bus.rd_data, 16'h0003);
    rd(1'b0);
    chk("stat.snap", bus.rd_data, 16'h0040);
    rd(1'b1);
    chk("stat.clear", bus.rd_data, 16'h0000);

    // Collision: data read on the same edge stable goes 00 -> 04.
    pins = 8'h00;
    cycn(8);
    rd(1'b0);
    pins = 8'h04;
    cycn(1 + DC);
    rd(1'b0);
    chk("coll.old", bus.rd_data, 16'h0000);
    chk("coll.pend", 16'(bus.pending), 16'h1);
    cycn(2);
    rd(1'b1);
    chk("coll.no_ovf", bus.rd_data, 16'h0001);
    rd(1'b0);
    chk("coll.new", bus.rd_data, 16'h0020);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) pins = 8'($urandom);
      bus.rd_req = ($urandom_range(0, 2) == 0);
      bus.rd_sel = 1'($urandom);
      cyc();
    end
    bus.rd_req = 1'b0;
    cycn(2);

    // Reset mid-debounce and mid-read: immediate clear, no valid pulse.
    pins = ~pins;
    cycn(3);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst.data",    bus.rd_data,       16'h0000);
    chk("arst.valid",   16'(bus.rd_valid), 16'h0);
    chk("arst.pending", 16'(bus.pending),  16'h0);
    chk("arst.irq",     16'(bus.irq),      16'h0);
    @(posedge clk);
    @(negedge clk);
    chk("arst.no_pulse", 16'(bus.rd_valid), 16'h0);
    bus.rd_req = 1'b0;
    rst = 1'b1;
    cycn(2 + DC + 3);
    rd(1'b0);
    chk("arst.resnap", bus.rd_data, {8'h00, rev8(pins)});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/phone_input_port.md
Name: phone_input_port

Overview:
- Parametrised successor to the fixed 8-line phone input path feeding the register-file write mux.
- Synchronises N asynchronous input lines and debounces each line individually.
- Holds a stable snapshot and flags changes to the CPU through a read handshake with pending/overflow status.
- Sits between the board input pins and the CPU datapath. The FSM issues reads; the returned data drives the regfile write bus.

Parameters:
- NUM_IN, 8: number of input lines (1..16).
- DATA_W, 16: CPU data-bus width; the snapshot is zero-extended into it.
- DEBOUNCE_CYCLES, 16: consecutive synchronised-mismatch cycles before a line's stable value updates. 0 bypasses debounce.
- BIT_REVERSE, 1: 1 maps in[0] to snapshot bit NUM_IN-1 (legacy ordering); 0 maps in[i] to bit i.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- in_pins, input, NUM_IN: raw asynchronous input lines.
- rd_req, input, 1: single-cycle read strobe from the FSM.
- rd_sel, input, 1: 0 = data read, 1 = status read.
- rd_data, output, DATA_W: read result, valid when rd_valid=1.
- rd_valid, output, 1: one-cycle pulse the cycle after rd_req.
- pending, output, 1: the stable snapshot changed since the last data read.
- irq, output, 1: interrupt request (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): all sync flops, stable register, debounce counters, pending, overflow, rd_data, rd_valid and irq are 0.
- Synchroniser: 2-flop chain per line. No logic between the two flops.
- Debounce, per line, counter width clog2(DEBOUNCE_CYCLES+1):
  - synced == stable: counter is 0.
  - synced != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - synced != stable and counter == DEBOUNCE_CYCLES-1: stable takes synced and counter clears on that edge.
  - A mismatch that returns to match before the limit clears the counter and produces no update (glitch rejected).
  - DEBOUNCE_CYCLES=0: stable takes synced every cycle.
- Latency: pin change to stable update = 2 + DEBOUNCE_CYCLES rising edges, or 3 when DEBOUNCE_CYCLES=0.
- Change detect: any stable bit update in a cycle sets pending on the next edge. If pending is already 1, overflow is also set.
- Read handshake:
  - rd_req sampled high gives rd_valid=1 on the next cycle, with rd_data registered.
  - rd_sel=0: rd_data = zero-extended snapshot (BIT_REVERSE applied), taken from the stable value before any same-cycle update. pending and overflow clear.
  - rd_sel=1: rd_data = {DATA_W-2 zeros, overflow, pending}. No flags change.
  - rd_req held high for several cycles is treated as one read per cycle.
- Simultaneous data read and stable update in the same cycle: the read returns the old value, and pending stays 1 (set wins over clear). overflow is cleared.
- rd_data holds its last value when rd_valid=0.
- Reset asserted mid-debounce or mid-read: all state returns to reset values immediately. No rd_valid pulse follows.
- NUM_IN > DATA_W is illegal. The design fails elaboration via a generate-time check.

Optional Feature:
- Macro: PHONE_INPUT_IRQ_EN.
- Defined: irq is a registered level equal to pending. It asserts the cycle after pending rises and drops the cycle after the clearing data read.
- Undefined: irq is tied to 0 and no extra flops are inferred. All other behaviour is unchanged.

Test Plan:
- Reset: drive rst=0 with in_pins=8'hFF. Required: all outputs 0. Release rst and hold in_pins: stable=8'hFF after 18 edges, then pending=1.
- Debounce (DEBOUNCE_CYCLES=4): raise in_pins[0] for 3 cycles, then drop it. Required: no pending and snapshot unchanged. Hold it 4+ cycles: pending=1 on edge 7 after the pin change.
- Data read (BIT_REVERSE=1): stable in_pins=8'b0000_0001, pulse rd_req with rd_sel=0. Required: next cycle rd_valid=1, rd_data=16'h0080, pending=0.
- Overflow/status: cause two stable changes with no read, then rd_sel=1 read. Required: rd_data=16'h0003. A following data read clears both, and the next status read returns 16'h0000.
- Collision: a data read lands in the same cycle as a stable update from 8'h00 to 8'h04. Required: rd_data=16'h0000 and pending remains 1. The next data read returns 16'h0020.
- PHONE_INPUT_IRQ_EN: compile with and without the macro and repeat the debounce case. Required: irq rises one cycle after pending when the macro is defined; irq stays constant 0 when it is not.
